// File: rtl/serial_7E1_pkg.sv
// Shared definitions for the 7E1 serial link: FSM state codes, timing defaults,
// data width and parity mode.
package serial_7E1_pkg;

    localparam int M_DEFAULT = 434;   // 50 MHz / 115200 baud
    localparam int N_DEFAULT = 13;    // wide enough for 5208 (9600 baud)
    localparam int DATA_W    = 7;

    typedef enum logic { PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1 } parity_mode_t;
    localparam parity_mode_t PARITY_MODE = PARITY_EVEN;

    // Receiver FSM codes; also exported raw on db_estado.
    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        REPOUSO  = 4'd1,
        INICIO   = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        PARADA   = 4'd5,
        ARMAZENA = 4'd6,
        ESPERA   = 4'd7
    } estado_t;

    // 1 when the received parity bit does not match the data under PARITY_MODE.
    function automatic logic paridade_errada(input logic [DATA_W-1:0] dado,
                                             input logic bit_paridade);
        return (^dado) ^ bit_paridade ^ (PARITY_MODE == PARITY_ODD);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Bit-timing counter: counts 0..M-1 and wraps; flags the half-bit and
// full-bit points. A synchronous clear realigns it to a sample instant.
module contador_m #(
    parameter int M = 434,
    parameter int N = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    output logic meio,
    output logic fim
);

    localparam logic [N-1:0] CONTA_MEIO = N'(M / 2 - 1);
    localparam logic [N-1:0] CONTA_FIM  = N'(M - 1);

    logic [N-1:0] valor;

    // Count up, restarting from zero on request or at the end of a bit period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera || fim) begin
            valor <= '0;
        end else begin
            valor <= valor + 1'b1;
        end
    end

    assign meio = (valor == CONTA_MEIO);
    assign fim  = (valor == CONTA_FIM);

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver with tem_dado/recebe_dado handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INICIAL  | post-reset, moves to REPOUSO on the next cycle
// REPOUSO  | idle, waiting for a falling edge on the synchronized line
// INICIO   | start bit, checked at mid-bit (false start -> REPOUSO)
// DADOS    | shifting in 7 data bits, LSB first
// PARIDADE | sampling the parity bit
// PARADA   | sampling the stop bit; result is committed on leaving
// ARMAZENA | result visible, pronto high for this one cycle
// ESPERA   | stop bit was low; waits for the line to return high
module rx_serial_7e1
    import serial_7E1_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dado_serial,
    input  logic              recebe_dado,
    output logic [DATA_W-1:0] dados_ascii,
    output logic              tem_dado,
    output logic              pronto,
    output logic              erro_paridade,
    output logic              erro_stop,
    output logic              overrun,
    output logic [3:0]        db_estado
);

    estado_t           estado;
    logic              rx_meta, rx_sync, rx_hist;
    logic              borda;
    logic              meio, fim;
    logic              zera;
    logic [DATA_W-1:0] registro;
    logic [2:0]        indice;
    logic              bit_paridade;

    // Two-flop synchronizer plus one history flop for edge detection; idle-high reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            rx_meta <= dado_serial;
            rx_sync <= rx_meta;
            rx_hist <= rx_sync;
        end
    end

    assign borda = rx_hist & ~rx_sync;

    // Hold the timer at zero while idle and realign it after every sample.
    always_comb begin
        zera = 1'b0;
        case (estado)
            REPOUSO:                  zera = 1'b1;
            INICIO:                   zera = meio;
            DADOS, PARIDADE, PARADA:  zera = fim;
            default:                  zera = 1'b0;
        endcase
    end

    contador_m #(.M(M), .N(N)) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .meio  (meio),
        .fim   (fim)
    );

    // Frame sequencing and registered outputs. The result is committed on the
    // PARADA->ARMAZENA edge so it is visible during ARMAZENA; a store in the
    // same cycle as recebe_dado overrides the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= INICIAL;
            registro      <= '0;
            indice        <= '0;
            bit_paridade  <= 1'b0;
            dados_ascii   <= '0;
            tem_dado      <= 1'b0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (recebe_dado) begin
                tem_dado <= 1'b0;
            end
            case (estado)
                INICIAL: estado <= REPOUSO;
                REPOUSO: begin
                    if (borda) begin
                        estado <= INICIO;
                    end
                end
                INICIO: begin
                    if (meio) begin
                        if (!rx_sync) begin
                            estado <= DADOS;
                            indice <= '0;
                        end else begin
                            estado <= REPOUSO;
                        end
                    end
                end
                DADOS: begin
                    if (fim) begin
                        registro <= {rx_sync, registro[DATA_W-1:1]};
                        if (indice == 3'd6) begin
                            estado <= PARIDADE;
                        end else begin
                            indice <= indice + 3'd1;
                        end
                    end
                end
                PARIDADE: begin
                    if (fim) begin
                        bit_paridade <= rx_sync;
                        estado       <= PARADA;
                    end
                end
                PARADA: begin
                    if (fim) begin
                        estado        <= ARMAZENA;
                        dados_ascii   <= registro;
                        erro_paridade <= paridade_errada(registro, bit_paridade);
                        erro_stop     <= ~rx_sync;
                        pronto        <= 1'b1;
                        tem_dado      <= 1'b1;
                        if (tem_dado) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                ARMAZENA: estado <= erro_stop ? ESPERA : REPOUSO;
                ESPERA: begin
                    if (rx_sync) begin
                        estado <= REPOUSO;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Self-checking bench for rx_serial_7e1: directed scenarios plus random frames,
// compared against a frame-level reference model.
module tb_rx_serial_7e1;

    localparam int M = 434;
    localparam int LAT_MIN = M / 2 + 9 * M + 2 - 1;   // pin fall to pronto, t0 = pin+2..3, +/-1
    localparam int LAT_MAX = M / 2 + 9 * M + 3 + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dado_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       tem_dado, pronto, erro_paridade, erro_stop, overrun;
    logic [3:0] db_estado;

    rx_serial_7e1 #(.M(M), .N(13)) dut (
        .clock         (clock),
        .reset         (reset),
        .dado_serial   (dado_serial),
        .recebe_dado   (recebe_dado),
        .dados_ascii   (dados_ascii),
        .tem_dado      (tem_dado),
        .pronto        (pronto),
        .erro_paridade (erro_paridade),
        .erro_stop     (erro_stop),
        .overrun       (overrun),
        .db_estado     (db_estado)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    int pronto_cnt = 0;
    int last_pronto = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt++;
            last_pronto = cyc;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: what the consumer should currently see.
    logic [6:0] m_data = '0;
    bit m_tem = 0, m_perr = 0, m_serr = 0, m_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int ones(input logic [6:0] d);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(d[i]);
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".dados_ascii"},   32'(dados_ascii),   32'(m_data));
        chk({tag, ".tem_dado"},      32'(tem_dado),      32'(m_tem));
        chk({tag, ".erro_paridade"}, 32'(erro_paridade), 32'(m_perr));
        chk({tag, ".erro_stop"},     32'(erro_stop),     32'(m_serr));
        chk({tag, ".overrun"},       32'(overrun),       32'(m_ovr));
    endtask

    task automatic ack();
        recebe_dado = 1'b1;
        tick(1);
        recebe_dado = 1'b0;
        m_tem = 0;
        tick(1);
        chk("ack.tem_dado", 32'(tem_dado), 32'(0));
    endtask

    // Drive one whole frame on the line and check the stored result.
    task automatic send_frame(input string tag, input logic [6:0] d, input bit bad_par,
                              input bit stop, input int stop_len);
        int p0, t_start, lat;
        logic par;
        p0 = pronto_cnt;
        t_start = cyc;
        dado_serial = 1'b0;
        tick(M);
        for (int i = 0; i < 7; i++) begin
            dado_serial = d[i];
            tick(M);
        end
        par = logic'(ones(d) % 2) ^ logic'(bad_par);
        dado_serial = par;
        tick(M);
        dado_serial = stop;
        tick(stop_len);
        lat = last_pronto - t_start;
        chk({tag, ".pronto_count"}, 32'(pronto_cnt - p0), 32'(1));
        if (lat < LAT_MIN || lat > LAT_MAX)
            chk({tag, ".pronto_latency"}, 32'(lat), 32'(LAT_MIN + 1));
        else
            checks++;
        if (m_tem) m_ovr = 1;
        m_tem  = 1;
        m_data = d;
        m_perr = bad_par;
        m_serr = !stop;
        check_outputs(tag);
    endtask

    initial begin
        int p0;
        logic [6:0] rd;
        bit rbad;

        // Reset state
        tick(3);
        check_outputs("reset");
        chk("reset.pronto", 32'(pronto), 32'(0));
        chk("reset.db_estado", 32'(db_estado), 32'(0));
        reset = 1'b1;
        tick(5);
        chk("idle.db_estado", 32'(db_estado), 32'(1));

        // 'A', clean frame
        send_frame("A", 7'h41, 0, 1, M);
        ack();

        // 'C' with wrong parity
        send_frame("C", 7'h43, 1, 1, M);
        ack();
        tick(20);

        // False start: line low for 100 cycles
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        tick(100);
        dado_serial = 1'b1;
        tick(50);
        chk("false_start.inicio", 32'(db_estado), 32'(2));
        tick(75);
        chk("false_start.repouso", 32'(db_estado), 32'(1));
        chk("false_start.no_pronto", 32'(pronto_cnt - p0), 32'(0));
        check_outputs("false_start");

        // 'Z' with low stop bit, line held low for 2M in total
        send_frame("Z", 7'h5A, 0, 0, M);
        chk("Z.espera", 32'(db_estado), 32'(7));
        tick(M);
        chk("Z.espera_hold", 32'(db_estado), 32'(7));
        dado_serial = 1'b1;
        tick(4);
        chk("Z.recover", 32'(db_estado), 32'(1));
        ack();
        send_frame("31", 7'h31, 0, 1, M);
        ack();

        // Back-to-back frames without acknowledge
        send_frame("55", 7'h55, 0, 1, M);
        send_frame("2A", 7'h2A, 0, 1, M);
        tick(10);

        // Reset during DADOS of 0x7F
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        tick(M);
        dado_serial = 1'b1;
        tick(2 * M + 100);
        reset = 1'b0;
        #1;
        m_data = '0; m_tem = 0; m_perr = 0; m_serr = 0; m_ovr = 0;
        check_outputs("async_reset");
        chk("async_reset.pronto", 32'(pronto), 32'(0));
        chk("async_reset.db_estado", 32'(db_estado), 32'(0));
        tick(2);
        reset = 1'b1;
        tick(6 * M);
        chk("after_reset.no_pronto", 32'(pronto_cnt - p0), 32'(0));
        chk("after_reset.db_estado", 32'(db_estado), 32'(1));
        check_outputs("after_reset");
        send_frame("30", 7'h30, 0, 1, M);

        // Random frames
        for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 1) == 1) ack();
            tick($urandom_range(0, 60));
            rd = 7'($urandom_range(0, 127));
            rbad = ($urandom_range(0, 3) == 0);
            send_frame("rand", rd, rbad, 1, M);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7E1

Asynchronous serial receiver for 7E1 frames (1 start, 7 data bits LSB first, even parity, 1 stop) at 115200 baud from a 50 MHz clock. It is the counterpart of the 7E1 transmitter on the same link. It samples the line, reconstructs the ASCII character, checks parity and stop bit, and holds the result for the consuming logic under a `tem_dado`/`recebe_dado` handshake.

## Interface
- `M`, 434, clock cycles per bit (50M/115200); 5208 for 9600 baud.
- `N`, 13, width of the bit-timing counter.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dado_serial`  in  1  RX line, idle high, asynchronous to `clock`.
- `recebe_dado`  in  1  consumer acknowledge; clears `tem_dado`.
- `dados_ascii`  out  7  last received character.
- `tem_dado`  out  1  character available, level.
- `pronto`  out  1  one-cycle pulse per completed frame.
- `erro_paridade`  out  1  parity error of the frame in `dados_ascii`.
- `erro_stop`  out  1  stop bit sampled low for that frame.
- `overrun`  out  1  sticky; a frame was stored while `tem_dado` was 1.
- `db_estado`  out  4  raw FSM state code.

## Operation
- Reset (`reset`=0) clears everything immediately:
  - Outputs go to 0, `dados_ascii` to 0x00.
  - FSM goes to INICIAL.
  - The synchronizer flops load 1.
- `dado_serial` passes through a 2-flop synchronizer, plus one history flop for falling-edge detection.
- FSM states, with 4-bit codes shared in the package:
  - INICIAL (0): next cycle goes to REPOUSO.
  - REPOUSO (1): waits for a synchronized falling edge. On the edge, zero the counter and go to INICIO.
  - INICIO (2): at count M/2-1, sample the line.
    - Line low: go to DADOS with the bit index at 0.
    - Line high: false start, go to REPOUSO.
  - DADOS (3): every M cycles, shift the sample into bit [6] of the shift register (LSB arrives first). After 7 samples go to PARIDADE.
  - PARIDADE (4): after M cycles, sample the parity bit.
  - PARADA (5): after M cycles, sample the stop bit, then go to ARMAZENA.
  - ARMAZENA (6): one cycle.
    - Load `dados_ascii`.
    - Set `erro_paridade` = XOR(data, parity).
    - Set `erro_stop` = NOT stop.
    - Pulse `pronto`, set `tem_dado`.
    - If `tem_dado` was already 1, set `overrun`.
    - Next state: REPOUSO if the stop bit was 1, else ESPERA.
  - ESPERA (7): break/framing recovery. Stays here until the synchronized line is high, then goes to REPOUSO.
- Data is stored even when an error is flagged.
- `erro_paridade` and `erro_stop` are updated only in ARMAZENA.
- Handshake:
  - `recebe_dado`=1 clears `tem_dado` on the next edge.
  - If it coincides with ARMAZENA, the store wins and `tem_dado` stays 1.
  - `overrun` clears only on reset.
- Codes 8–15 are illegal and go to INICIAL.

## Timing
- t0 is the cycle in which the synchronized falling edge is seen. This is 2–3 cycles after the pin transition.
- Start sample: t0+M/2 (t0+217).
- Data bit i (i=0..6): t0+M/2+M·(i+1).
- Parity bit: t0+M/2+8M.
- Stop bit: t0+M/2+9M.
- ARMAZENA, `pronto`, and the `tem_dado` rise occur at the stop-bit sample cycle +1. With defaults this is about 4124 cycles after t0.
- A new frame is detected from the cycle after ARMAZENA. Back-to-back frames from the transmitter are therefore received without loss.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `serial_7E1_pkg`:
  - State code constants.
  - Defaults for `M` and `N`.
  - Data width 7.
  - Parity mode constant (even).
- Reuse `contador_m` as the bit-timing sub-module:
  - Zeroed by the FSM on the start edge and after each sample.
  - Its `meio` output provides the M/2 point in INICIO; `fim` marks full-bit points elsewhere.
- The remaining logic stays in one module: synchronizer, shift register, 3-bit bit index, and FSM with registered outputs.

## Test plan
- 'A' (0x41, parity 0, stop 1) → `pronto` pulse at t0+4124±1, `dados_ascii`=0x41, `tem_dado`=1, both error flags 0.
- 'C' (0x43) sent with parity 0 → `dados_ascii`=0x43, `erro_paridade`=1. Then `recebe_dado` for 1 cycle → `tem_dado`=0.
- Line low for 100 cycles then high → FSM back in REPOUSO by t0+218, no `pronto`, outputs unchanged.
- 'Z' (0x5A) with stop bit 0, line held low for 2M → `erro_stop`=1, FSM stays in ESPERA (7) until the line is high, then the next frame 0x31 is received correctly.
- Two frames back-to-back (0x55, then 0x2A) without `recebe_dado` → `overrun`=1, `dados_ascii`=0x2A, `tem_dado`=1.
- Assert `reset`=0 during DADOS of frame 0x7F → all outputs 0 immediately. After release, the remaining bits produce no `pronto`, and a fresh 0x30 is received correctly.
